romix_scratchpad: RTL and testbench

- Scratchpad (V array) controller for the scrypt ROMix loops; the storage/readback end of the salsa pipeline's state and address outputs.
- Write phase: stores each successive 1024-bit X state (X0 half, X1 half) produced by the salsa pipeline.
- Read phase: accepts the data-dependent index taken from the low bits of the salsa output and returns V[index] with fixed latency.
- Sits between the salsa pipeline and the hashing-core sequencer.

---
 rtl/romix_scratchpad.sv | 160 ++++++++++++++++
 tb/tb_romix_scratchpad.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/romix_scratchpad.sv
// romix_scratchpad: V-array scratchpad for the scrypt ROMix loops.
// Stores N successive 1024-bit X states in the write phase. In the read phase
// it returns V[xaddr] a fixed RD_LAT cycles after each accepted request.
// Optional build macro ROMIX_HALFRAM_EN: only even-indexed entries are kept
// (N/2 deep). Odd reads return the even neighbour and flag rd_recompute so
// the consumer can run one extra salsa pass.
module romix_scratchpad #(
  parameter int ADDR_BITS = 10,
  parameter int RD_LAT    = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 din_valid,
  input  logic [511:0]         din_x0,
  input  logic [511:0]         din_x1,
  input  logic                 xaddr_valid,
  input  logic [ADDR_BITS-1:0] xaddr,
  output logic                 wr_ready,
  output logic                 rd_ready,
  output logic                 rd_valid,
  output logic [511:0]         rd_x0,
  output logic [511:0]         rd_x1,
  output logic                 rd_recompute,
  output logic                 busy,
  output logic                 done
);

`ifdef ROMIX_HALFRAM_EN
  localparam int RAM_AW = ADDR_BITS - 1;
`else
  localparam int RAM_AW = ADDR_BITS;
`endif
  localparam int DEPTH = 1 << RAM_AW;
  localparam logic [ADDR_BITS-1:0] LAST_IDX = '1;
  // Every read-pipe stage except the output one; DRAIN ends when these are clear.
  localparam logic [RD_LAT-1:0] LOWER_MASK = {RD_LAT{1'b1}} >> 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_BITS-1:0]  wr_cnt_q, wr_cnt_d;
  logic [ADDR_BITS-1:0]  rd_cnt_q, rd_cnt_d;

  logic [1023:0]         mem [DEPTH];

  logic                  wr_acc, rd_acc, wr_en, rc_in;
  logic [RAM_AW-1:0]     waddr, raddr;

  logic [RD_LAT-1:0]          vld_q;
  logic [RD_LAT-1:0]          rc_q;
  logic [RD_LAT-1:0][1023:0]  dat_q;

  assign wr_acc = (state_q == S_WRITE) && din_valid;
  assign rd_acc = (state_q == S_READ) && xaddr_valid;

`ifdef ROMIX_HALFRAM_EN
  // Odd states are dropped; their readers get the even predecessor plus a flag.
  assign waddr = wr_cnt_q[ADDR_BITS-1:1];
  assign raddr = xaddr[ADDR_BITS-1:1];
  assign wr_en = wr_acc && !wr_cnt_q[0];
  assign rc_in = xaddr[0];
`else
  assign waddr = wr_cnt_q;
  assign raddr = xaddr;
  assign wr_en = wr_acc;
  assign rc_in = 1'b0;
`endif

  // Next-state and counter logic for the job sequence.
  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_WRITE;
          wr_cnt_d = '0;
          rd_cnt_d = '0;
        end
      end
      S_WRITE: begin
        if (din_valid) begin
          wr_cnt_d = wr_cnt_q + 1'b1;
          if (wr_cnt_q == LAST_IDX) state_d = S_READ;
        end
      end
      S_READ: begin
        if (xaddr_valid) begin
          rd_cnt_d = rd_cnt_q + 1'b1;
          if (rd_cnt_q == LAST_IDX) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if ((vld_q & LOWER_MASK) == '0) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  // Scratchpad write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[waddr] <= {din_x1, din_x0};
  end

  // Read pipe: stage 0 is the synchronous RAM read; data stages only load
  // behind a valid so the output holds its last value between returns.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      rc_q  <= '0;
      dat_q <= '0;
    end else begin
      vld_q[0] <= rd_acc;
      if (rd_acc) begin
        dat_q[0] <= mem[raddr];
        rc_q[0]  <= rc_in;
      end
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          dat_q[i] <= dat_q[i-1];
          rc_q[i]  <= rc_q[i-1];
        end
      end
    end
  end

  assign rd_valid     = vld_q[RD_LAT-1];
  assign rd_x0        = dat_q[RD_LAT-1][511:0];
  assign rd_x1        = dat_q[RD_LAT-1][1023:512];
  assign rd_recompute = rc_q[RD_LAT-1];

  assign wr_ready = (state_q == S_WRITE);
  assign rd_ready = (state_q == S_READ);
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_romix_scratchpad.sv
// Bench for romix_scratchpad (ADDR_BITS=4, RD_LAT=2). Keeps an array model of
// V and predicts each return's cycle, data and recompute flag.
module tb_romix_scratchpad;
  localparam int AB = 4;
  localparam int RL = 2;
  localparam int NW = 16;
`ifdef ROMIX_HALFRAM_EN
  localparam bit HALF = 1'b1;
`else
  localparam bit HALF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          din_valid = 1'b0;
  logic [511:0]  din_x0 = '0;
  logic [511:0]  din_x1 = '0;
  logic          xaddr_valid = 1'b0;
  logic [AB-1:0] xaddr = '0;
  logic          wr_ready, rd_ready, rd_valid, rd_recompute, busy, done;
  logic [511:0]  rd_x0, rd_x1;

  romix_scratchpad #(.ADDR_BITS(AB), .RD_LAT(RL)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .din_valid(din_valid),
    .din_x0(din_x0), .din_x1(din_x1), .xaddr_valid(xaddr_valid), .xaddr(xaddr),
    .wr_ready(wr_ready), .rd_ready(rd_ready), .rd_valid(rd_valid),
    .rd_x0(rd_x0), .rd_x1(rd_x1), .rd_recompute(rd_recompute),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed returns and done pulses, stamped with their cycle.
  int           cap_cyc[$];
  logic [511:0] cap_x0[$];
  logic [511:0] cap_x1[$];
  logic         cap_rc[$];
  int           done_cyc[$];

  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      cap_cyc.push_back(cyc);
      cap_x0.push_back(rd_x0);
      cap_x1.push_back(rd_x1);
      cap_rc.push_back(rd_recompute);
    end
    if (done === 1'b1) done_cyc.push_back(cyc);
  end

  // Reference model: V as written, plus expected returns in order.
  logic [1023:0] mdl [NW];
  int           exp_cyc[$];
  logic [511:0] exp_x0[$];
  logic [511:0] exp_x1[$];
  logic         exp_rc[$];
  int           last_req;

  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic check_idle_zero(input string tag);
    chk({tag, "_wr_ready"}, 512'(wr_ready), 512'd0);
    chk({tag, "_rd_ready"}, 512'(rd_ready), 512'd0);
    chk({tag, "_rd_valid"}, 512'(rd_valid), 512'd0);
    chk({tag, "_rd_recompute"}, 512'(rd_recompute), 512'd0);
    chk({tag, "_busy"}, 512'(busy), 512'd0);
    chk({tag, "_done"}, 512'(done), 512'd0);
    chk({tag, "_rd_x0"}, rd_x0, 512'd0);
    chk({tag, "_rd_x1"}, rd_x1, 512'd0);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", 512'(busy), 512'd1);
    chk("start_wr_ready", 512'(wr_ready), 512'd1);
  endtask

  // Fill all NW entries; optional idle gaps and ignored-strobe noise.
  task automatic write_job(input bit gaps, input bit pattern, input bit noise);
    for (int i = 0; i < NW; i++) begin
      logic [511:0] a, b;
      if (pattern) begin
        a = {16{32'(i)}};
        b = ~a;
      end else begin
        a = rnd512();
        b = rnd512();
      end
      if (gaps) begin
        din_valid = 1'b0;
        din_x0 = rnd512();
        din_x1 = rnd512();
        tick();
      end
      if (i == NW - 1) begin
        chk("wr_ready_before_last", 512'(wr_ready), 512'd1);
        chk("rd_ready_before_last", 512'(rd_ready), 512'd0);
      end
      din_valid = 1'b1;
      din_x0 = a;
      din_x1 = b;
      mdl[i] = {b, a};
      if (noise) begin
        xaddr_valid = 1'b1;
        xaddr = AB'($urandom);
        start = (i == 8);
      end
      tick();
    end
    din_valid = 1'b0;
    xaddr_valid = 1'b0;
    start = 1'b0;
    chk("rd_ready_after_last", 512'(rd_ready), 512'd1);
    chk("wr_ready_after_last", 512'(wr_ready), 512'd0);
  endtask

  task automatic read_one(input int a);
    int idx;
    idx = HALF ? (a & ~1) : a;
    xaddr_valid = 1'b1;
    xaddr = a[AB-1:0];
    exp_cyc.push_back(cyc + RL);
    exp_x0.push_back(mdl[idx][511:0]);
    exp_x1.push_back(mdl[idx][1023:512]);
    exp_rc.push_back(HALF ? a[0] : 1'b0);
    last_req = cyc;
    tick();
  endtask

  task automatic check_reads(input string tag);
    int n;
    n = exp_cyc.size();
    for (int t = 0; t < 40 && cap_cyc.size() < n; t++) tick();
    chk({tag, "_count"}, 512'(cap_cyc.size()), 512'(n));
    while (exp_cyc.size() > 0 && cap_cyc.size() > 0) begin
      chk({tag, "_cycle"}, 512'(cap_cyc.pop_front()), 512'(exp_cyc.pop_front()));
      chk({tag, "_x0"}, cap_x0.pop_front(), exp_x0.pop_front());
      chk({tag, "_x1"}, cap_x1.pop_front(), exp_x1.pop_front());
      chk({tag, "_rc"}, 512'(cap_rc.pop_front()), 512'(exp_rc.pop_front()));
    end
    exp_cyc.delete(); exp_x0.delete(); exp_x1.delete(); exp_rc.delete();
    cap_cyc.delete(); cap_x0.delete(); cap_x1.delete(); cap_rc.delete();
  endtask

  // done must pulse once at last_req+RL+1; busy is low the cycle after.
  task automatic check_done(input string tag);
    for (int t = 0; t < 50 && cyc < last_req + RL + 3; t++) tick();
    chk({tag, "_done_count"}, 512'(done_cyc.size()), 512'd1);
    if (done_cyc.size() > 0)
      chk({tag, "_done_cycle"}, 512'(done_cyc[0]), 512'(last_req + RL + 1));
    chk({tag, "_busy_low"}, 512'(busy), 512'd0);
    done_cyc.delete();
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    check_idle_zero("reset");
    reset_n = 1'b1;
    tick();

    // Job 1: directed pattern with ignored strobes
    din_valid = 1'b1;
    din_x0 = rnd512();
    din_x1 = rnd512();
    start = 1'b1;
    tick();
    start = 1'b0;
    din_valid = 1'b0;
    chk("job1_busy", 512'(busy), 512'd1);
    chk("job1_wr_ready", 512'(wr_ready), 512'd1);
    write_job(1'b0, 1'b1, 1'b1);
    chk("write_no_rd_valid", 512'(cap_cyc.size()), 512'd0);
    din_valid = 1'b1;
    din_x0 = rnd512();
    din_x1 = rnd512();
    repeat (2) tick();
    din_valid = 1'b0;
    read_one(5);
    xaddr_valid = 1'b0;
    check_reads("basic5");
    read_one(7);
    read_one(6);
    read_one(0);
    read_one(15);
    for (int k = 0; k < 11; k++) read_one(int'($urandom_range(0, NW - 1)));
    xaddr_valid = 1'b0;
    check_reads("job1");
    check_done("job1");

    // Job 2: strobes in IDLE, write gaps, back-to-back descending reads
    din_valid = 1'b1;
    din_x0 = rnd512();
    din_x1 = rnd512();
    repeat (2) tick();
    din_valid = 1'b0;
    chk("idle_din_busy", 512'(busy), 512'd0);
    do_start();
    write_job(1'b1, 1'b0, 1'b0);
    for (int a = NW - 1; a >= 0; a--) read_one(a);
    xaddr_valid = 1'b0;
    check_reads("b2b");
    check_done("job2");

    // Job 3: reset one cycle after a read request
    do_start();
    write_job(1'b0, 1'b0, 1'b0);
    xaddr_valid = 1'b1;
    xaddr = 4'd3;
    tick();
    xaddr_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check_idle_zero("midreset");
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    chk("midreset_no_rd_valid", 512'(cap_cyc.size()), 512'd0);
    cap_cyc.delete(); cap_x0.delete(); cap_x1.delete(); cap_rc.delete();
    done_cyc.delete();

    // Job 4: fresh data after reset
    do_start();
    write_job(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < NW; k++) read_one(int'($urandom_range(0, NW - 1)));
    xaddr_valid = 1'b0;
    check_reads("job4");
    check_done("job4");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
